// File: rtl/calc_sched_pkg.sv
// Shared types for the calc1 request scheduler: command/response codes, port states
// and the command validity check.
package calc_sched_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE    = 2'd0,
    RESP_OK      = 2'd1,
    RESP_OVF     = 2'd2,
    RESP_INVALID = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    PEND,
    ISSUED
  } port_state_e;

  // NOP never reaches a latched request, so it is treated as invalid here.
  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Picks one requesting port per cycle. Default is round-robin; defining
// CALC_SCHED_FIXED_PRIO_EN switches to fixed priority (lowest index wins, no pointer).
module calc_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int TAG_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 accept,
  input  logic [TAG_W-1:0]     accept_tag,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef CALC_SCHED_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = clk ^ reset ^ accept ^ (^accept_tag);

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  // ptr is the first port searched; it moves past a port only once the ALU takes it.
  logic [TAG_W-1:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      if (int'(accept_tag) == NUM_PORTS - 1) ptr <= '0;
      else                                   ptr <= accept_tag + 1'b1;
    end
  end

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/calc_req_scheduler.sv
// Front end for the shared calc1 ALU: per-port request capture, arbitration onto one
// registered issue interface, and tagged response return. Option: CALC_SCHED_FIXED_PRIO_EN.
module calc_req_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = $clog2(NUM_PORTS)
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic                        alu_req_valid,
  input  logic                        alu_req_ready,
  output logic [3:0]                  alu_cmd,
  output logic [DATA_W-1:0]           alu_op1,
  output logic [DATA_W-1:0]           alu_op2,
  output logic [TAG_W-1:0]            alu_tag,
  input  logic                        alu_rsp_valid,
  input  logic [1:0]                  alu_rsp_code,
  input  logic [DATA_W-1:0]           alu_rsp_data,
  input  logic [TAG_W-1:0]            alu_rsp_tag,
  output logic                        busy,
  output logic                        sched_err
);
  import calc_sched_pkg::*;

  logic [NUM_PORTS-1:0]        pend_vec, issued_vec, busy_vec, req_mask, grant;
  logic [NUM_PORTS*4-1:0]      cmd_flat;
  logic [NUM_PORTS*DATA_W-1:0] op1_flat, op2_flat;
  logic                        handshake, load;
  logic [3:0]                  sel_cmd;
  logic [DATA_W-1:0]           sel_op1, sel_op2;
  logic [TAG_W-1:0]            sel_tag;

  assign handshake = alu_req_valid & alu_req_ready;
  assign load      = ~alu_req_valid | alu_req_ready;
  assign busy      = |busy_vec;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_state_e       state, state_nxt;
    logic [3:0]        cmd_q, cmd_in;
    logic [DATA_W-1:0] op1_q, op2_q, data_in, rdata_q;
    logic [1:0]        resp_q;
    logic              take_issue, take_rsp, local_inv;

    assign cmd_in     = req_cmd_in[p*4 +: 4];
    assign data_in    = req_data_in[p*DATA_W +: DATA_W];
    assign take_issue = handshake && (alu_tag == TAG_W'(p));
    assign take_rsp   = alu_rsp_valid && (alu_rsp_tag == TAG_W'(p)) && (state == ISSUED);
    assign local_inv  = (state == OP2) && !is_valid_cmd(cmd_q);

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (cmd_in != 4'd0) state_nxt = OP2;
        OP2:     state_nxt = is_valid_cmd(cmd_q) ? PEND : IDLE;
        PEND:    if (take_issue) state_nxt = ISSUED;
        ISSUED:  if (take_rsp) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cmd_q <= '0;
        op1_q <= '0;
        op2_q <= '0;
      end else begin
        state <= state_nxt;
        if (state == IDLE && cmd_in != 4'd0) begin
          cmd_q <= cmd_in;
          op1_q <= data_in;
        end
        if (state == OP2) op2_q <= data_in;
      end
    end

    // A port is never in OP2 and ISSUED at once, so the two sources cannot collide.
    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
        resp_q  <= '0;
        rdata_q <= '0;
      end else begin
        resp_q  <= '0;
        rdata_q <= '0;
        if (local_inv) begin
          resp_q <= RESP_INVALID;
        end else if (take_rsp) begin
          resp_q  <= alu_rsp_code;
          rdata_q <= alu_rsp_data;
        end
      end
    end

    assign pend_vec[p]   = (state == PEND);
    assign issued_vec[p] = (state == ISSUED);
    assign busy_vec[p]   = (state != IDLE);
    assign cmd_flat[p*4 +: 4]           = cmd_q;
    assign op1_flat[p*DATA_W +: DATA_W] = op1_q;
    assign op2_flat[p*DATA_W +: DATA_W] = op2_q;
    assign out_resp[p*2 +: 2]           = resp_q;
    assign out_data[p*DATA_W +: DATA_W] = rdata_q;
  end

  // The port sitting in the issue register is still PEND; keep it out of the next pick.
  always_comb begin
    req_mask = pend_vec;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (alu_req_valid && alu_tag == TAG_W'(i)) req_mask[i] = 1'b0;
    end
  end

  calc_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .TAG_W     (TAG_W)
  ) u_arb (
    .clk        (c_clk),
    .reset      (reset),
    .req        (req_mask),
    .accept     (handshake),
    .accept_tag (alu_tag),
    .grant      (grant)
  );

  always_comb begin
    sel_cmd = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_cmd = cmd_flat[i*4 +: 4];
        sel_op1 = op1_flat[i*DATA_W +: DATA_W];
        sel_op2 = op2_flat[i*DATA_W +: DATA_W];
        sel_tag = TAG_W'(i);
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      alu_req_valid <= 1'b0;
      alu_cmd       <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_tag       <= '0;
    end else if (load) begin
      alu_req_valid <= |grant;
      if (|grant) begin
        alu_cmd <= sel_cmd;
        alu_op1 <= sel_op1;
        alu_op2 <= sel_op2;
        alu_tag <= sel_tag;
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset)                                          sched_err <= 1'b0;
    else if (alu_rsp_valid && !issued_vec[alu_rsp_tag]) sched_err <= 1'b1;
  end

endmodule

// File: tb/tb_calc_req_scheduler.sv
// Bench for calc_req_scheduler: directed scenarios plus randomized traffic against a
// per-port expected-response model and a simple in-order ALU stub.
module tb_calc_req_scheduler;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;

  logic             c_clk = 1'b0;
  logic             reset = 1'b1;
  logic [NP*4-1:0]  req_cmd_in = '0;
  logic [NP*DW-1:0] req_data_in = '0;
  logic [NP*2-1:0]  out_resp;
  logic [NP*DW-1:0] out_data;
  logic             alu_req_valid;
  logic             alu_req_ready = 1'b0;
  logic [3:0]       alu_cmd;
  logic [DW-1:0]    alu_op1, alu_op2;
  logic [TW-1:0]    alu_tag;
  logic             alu_rsp_valid = 1'b0;
  logic [1:0]       alu_rsp_code = '0;
  logic [DW-1:0]    alu_rsp_data = '0;
  logic [TW-1:0]    alu_rsp_tag = '0;
  logic             busy, sched_err;

  calc_req_scheduler #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req_cmd_in    (req_cmd_in),
    .req_data_in   (req_data_in),
    .out_resp      (out_resp),
    .out_data      (out_data),
    .alu_req_valid (alu_req_valid),
    .alu_req_ready (alu_req_ready),
    .alu_cmd       (alu_cmd),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_tag       (alu_tag),
    .alu_rsp_valid (alu_rsp_valid),
    .alu_rsp_code  (alu_rsp_code),
    .alu_rsp_data  (alu_rsp_data),
    .alu_rsp_tag   (alu_rsp_tag),
    .busy          (busy),
    .sched_err     (sched_err)
  );

  always #5 c_clk = ~c_clk;

  int cycle = 0;
  always @(posedge c_clk) cycle++;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_seen = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic the calc1 unit performs, written from the command definitions: {code, data}.
  function automatic logic [33:0] aluRef(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (cmd)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return {(s[32] ? 2'd2 : 2'd1), s[31:0]};
      end
      4'd2:    return {((a < b) ? 2'd2 : 2'd1), a - b};
      4'd5:    return {2'd1, a << b[4:0]};
      4'd6:    return {2'd1, a >> b[4:0]};
      default: return {2'd3, 32'd0};
    endcase
  endfunction

  // Expected outcome per port: one outstanding request at most.
  logic        exp_pend [NP];
  logic [1:0]  exp_code [NP];
  logic [31:0] exp_data [NP];
  logic        exp_inv  [NP];
  int          exp_cyc  [NP];

  initial for (int p = 0; p < NP; p++) exp_pend[p] = 1'b0;

  task automatic setExpect(input int p, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] r;
    r = aluRef(cmd, a, b);
    exp_pend[p] = 1'b1;
    exp_code[p] = r[33:32];
    exp_data[p] = r[31:0];
    exp_inv[p]  = (r[33:32] == 2'd3);
    exp_cyc[p]  = cycle;
  endtask

  // ALU stub: answers accepted issues in order after 1..3 cycles; also watches issue hold.
  typedef struct {
    logic [TW-1:0] tag;
    logic [33:0]   res;
    int            due;
  } rsp_t;

  rsp_t          alu_q[$];
  int            issue_tag_log[$];
  int            issue_cyc_log[$];
  logic          alu_hold = 1'b0;
  logic          prev_stall = 1'b0;
  logic [3:0]    prev_cmd;
  logic [DW-1:0] prev_op1, prev_op2;
  logic [TW-1:0] prev_tag;

  always @(negedge c_clk) begin : alu_model
    alu_rsp_valid = 1'b0;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", alu_req_valid, 1);
        checkOutput("hold_cmd", alu_cmd, prev_cmd);
        checkOutput("hold_op1", alu_op1, prev_op1);
        checkOutput("hold_op2", alu_op2, prev_op2);
        checkOutput("hold_tag", alu_tag, prev_tag);
      end
      prev_stall = alu_req_valid && !alu_req_ready;
      prev_cmd = alu_cmd;
      prev_op1 = alu_op1;
      prev_op2 = alu_op2;
      prev_tag = alu_tag;
      if (alu_req_valid && alu_req_ready) begin
        alu_q.push_back('{alu_tag, aluRef(alu_cmd, alu_op1, alu_op2), cycle + 1 + int'($urandom_range(0, 2))});
        issue_tag_log.push_back(int'(alu_tag));
        issue_cyc_log.push_back(cycle);
      end
    end
    if (!alu_hold && alu_q.size() > 0 && cycle >= alu_q[0].due) begin
      alu_rsp_valid = 1'b1;
      alu_rsp_tag   = alu_q[0].tag;
      alu_rsp_code  = alu_q[0].res[33:32];
      alu_rsp_data  = alu_q[0].res[31:0];
      void'(alu_q.pop_front());
    end
  end

  always @(negedge c_clk) begin : resp_monitor
    logic [1:0]  r;
    logic [31:0] d;
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        r = out_resp[p*2 +: 2];
        d = out_data[p*DW +: DW];
        if (r != 2'd0) begin
          resp_seen++;
          if (exp_pend[p]) begin
            checkOutput($sformatf("resp_code_p%0d", p), r, exp_code[p]);
            checkOutput($sformatf("resp_data_p%0d", p), d, exp_data[p]);
            if (exp_inv[p]) checkOutput($sformatf("inv_latency_p%0d", p), cycle - exp_cyc[p], 2);
            exp_pend[p] = 1'b0;
          end else begin
            checkOutput($sformatf("stray_resp_p%0d", p), r, 0);
          end
        end
      end
    end
  end

  // Same two-cycle request (cmd+op1, then op2) on every port in mask.
  task automatic applyStimulus(input logic [NP-1:0] mask, input logic [3:0] cmd,
                               input logic [31:0] a, input logic [31:0] b);
    @(posedge c_clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        req_cmd_in[p*4 +: 4]    = cmd;
        req_data_in[p*DW +: DW] = a;
        setExpect(p, cmd, a, b);
      end
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        req_cmd_in[p*4 +: 4]    = 4'd0;
        req_data_in[p*DW +: DW] = b;
      end
    end
  endtask

  task automatic waitIdle(input string tag, input int maxc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge c_clk); #1;
      done = !busy;
      for (int p = 0; p < NP; p++) if (exp_pend[p]) done = 1'b0;
    end
    checkOutput(tag, done, 1);
  endtask

  task automatic resetDut();
    @(posedge c_clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge c_clk);
    #1 reset = 1'b0;
    for (int p = 0; p < NP; p++) exp_pend[p] = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int base, rbase, t;
    int phase [NP];
    logic [31:0] op2_save [NP];
    logic [3:0]  cmd_pool [8];
    logic [3:0]  c;
    logic [31:0] a, b;

    cmd_pool = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};

    // Test 1: reset values
    repeat (3) @(posedge c_clk);
    #1 reset = 1'b0;
    @(negedge c_clk);
    checkOutput("t1_out_resp", out_resp, 0);
    checkOutput("t1_out_data", out_data, 0);
    checkOutput("t1_req_valid", alu_req_valid, 0);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_sched_err", sched_err, 0);

    // Test 2: single ADD on port 0
    alu_req_ready = 1'b1;
    rbase = resp_seen;
    applyStimulus(4'b0001, 4'd1, 32'h5, 32'h7);
    waitIdle("t2_idle", 40);
    checkOutput("t2_resp_count", resp_seen - rbase, 1);
    checkOutput("t2_busy", busy, 0);

    // Test 3: all ports at once, issued in port order on consecutive cycles
    resetDut();
    base = issue_tag_log.size();
    applyStimulus(4'b1111, 4'd1, 32'h10, 32'h20);
    waitIdle("t3_idle", 60);
    checkOutput("t3_issue_count", issue_tag_log.size() - base, 4);
    if (issue_tag_log.size() - base == 4) begin
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("t3_tag%0d", i), issue_tag_log[base+i], i);
      for (int i = 1; i < 4; i++)
        checkOutput($sformatf("t3_gap%0d", i), issue_cyc_log[base+i] - issue_cyc_log[base+i-1], 1);
    end

    // Test 4: invalid command answered locally, never issued
    base  = issue_tag_log.size();
    rbase = resp_seen;
    applyStimulus(4'b0100, 4'd4, 32'h1, 32'h0);
    waitIdle("t4_idle", 20);
    checkOutput("t4_issue_count", issue_tag_log.size() - base, 0);
    checkOutput("t4_resp_count", resp_seen - rbase, 1);

    // Test 5: SHL held under backpressure for 5 cycles, taken on the 6th
    alu_req_ready = 1'b0;
    base = issue_tag_log.size();
    applyStimulus(4'b0010, 4'd5, 32'h1, 32'h4);
    t = 0;
    while (!alu_req_valid && t < 20) begin
      @(negedge c_clk);
      t++;
    end
    checkOutput("t5_valid", alu_req_valid, 1);
    checkOutput("t5_cmd", alu_cmd, 5);
    checkOutput("t5_op1", alu_op1, 1);
    checkOutput("t5_op2", alu_op2, 4);
    checkOutput("t5_tag", alu_tag, 1);
    repeat (5) @(posedge c_clk);
    #1;
    checkOutput("t5_not_taken", issue_tag_log.size() - base, 0);
    alu_req_ready = 1'b1;
    waitIdle("t5_idle", 20);
    checkOutput("t5_taken", issue_tag_log.size() - base, 1);

    // Randomized traffic on all ports with random backpressure
    for (int p = 0; p < NP; p++) phase[p] = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge c_clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (phase[p] == 1) begin
          req_cmd_in[p*4 +: 4]    = 4'($urandom);
          req_data_in[p*DW +: DW] = op2_save[p];
          phase[p] = 0;
        end else if (!exp_pend[p] && ($urandom % 3 == 0)) begin
          c = cmd_pool[$urandom_range(0, 7)];
          a = $urandom;
          b = ($urandom % 2 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
          req_cmd_in[p*4 +: 4]    = c;
          req_data_in[p*DW +: DW] = a;
          op2_save[p] = b;
          setExpect(p, c, a, b);
          phase[p] = 1;
        end else begin
          req_cmd_in[p*4 +: 4]    = 4'd0;
          req_data_in[p*DW +: DW] = $urandom;
        end
      end
      alu_req_ready = ($urandom % 4 != 0);
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < NP; p++) begin
      req_cmd_in[p*4 +: 4] = 4'd0;
      if (phase[p] == 1) req_data_in[p*DW +: DW] = op2_save[p];
    end
    alu_req_ready = 1'b1;
    waitIdle("rand_idle", 200);
    checkOutput("rand_sched_err", sched_err, 0);

    // Test 6: stale ALU response after reset is dropped and flagged
    alu_hold = 1'b1;
    base = issue_tag_log.size();
    applyStimulus(4'b1000, 4'd1, 32'h3, 32'h4);
    t = 0;
    while (issue_tag_log.size() == base && t < 20) begin
      @(negedge c_clk);
      t++;
    end
    checkOutput("t6_issued", issue_tag_log.size() - base, 1);
    repeat (2) @(posedge c_clk);
    #1 reset = 1'b1;
    #1 checkOutput("t6_async_valid", alu_req_valid, 0);
    checkOutput("t6_async_busy", busy, 0);
    for (int p = 0; p < NP; p++) exp_pend[p] = 1'b0;
    repeat (2) @(posedge c_clk);
    #1 reset = 1'b0;
    rbase = resp_seen;
    alu_hold = 1'b0;
    repeat (6) @(posedge c_clk);
    @(negedge c_clk);
    checkOutput("t6_no_resp", resp_seen - rbase, 0);
    checkOutput("t6_sched_err", sched_err, 1);
    checkOutput("t6_rsp_consumed", alu_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
